// File: rtl/reg_execute_alu_pkg.sv
// Shared definitions for the RV32 execute stage: ALU function codes,
// function-code width and the divider control states.
package reg_execute_alu_pkg;

  localparam int ALU_FN_W = 5;

  localparam logic [ALU_FN_W-1:0] ALU_ADD    = 5'd0;
  localparam logic [ALU_FN_W-1:0] ALU_SUB    = 5'd1;
  localparam logic [ALU_FN_W-1:0] ALU_AND    = 5'd2;
  localparam logic [ALU_FN_W-1:0] ALU_OR     = 5'd3;
  localparam logic [ALU_FN_W-1:0] ALU_XOR    = 5'd4;
  localparam logic [ALU_FN_W-1:0] ALU_SLL    = 5'd5;
  localparam logic [ALU_FN_W-1:0] ALU_SRL    = 5'd6;
  localparam logic [ALU_FN_W-1:0] ALU_SRA    = 5'd7;
  localparam logic [ALU_FN_W-1:0] ALU_SLT    = 5'd8;
  localparam logic [ALU_FN_W-1:0] ALU_SLTU   = 5'd9;
  localparam logic [ALU_FN_W-1:0] ALU_JALR   = 5'd10;
  localparam logic [ALU_FN_W-1:0] ALU_COPY1  = 5'd11;
  localparam logic [ALU_FN_W-1:0] ALU_COPY2  = 5'd12;
  localparam logic [ALU_FN_W-1:0] ALU_MUL    = 5'd16;
  localparam logic [ALU_FN_W-1:0] ALU_MULH   = 5'd17;
  localparam logic [ALU_FN_W-1:0] ALU_MULHSU = 5'd18;
  localparam logic [ALU_FN_W-1:0] ALU_MULHU  = 5'd19;
  localparam logic [ALU_FN_W-1:0] ALU_DIV    = 5'd20;
  localparam logic [ALU_FN_W-1:0] ALU_DIVU   = 5'd21;
  localparam logic [ALU_FN_W-1:0] ALU_REM    = 5'd22;
  localparam logic [ALU_FN_W-1:0] ALU_REMU   = 5'd23;

  typedef enum logic [1:0] {
    EXE_IDLE = 2'd0,
    EXE_DIV  = 2'd1,
    EXE_DONE = 2'd2
  } exe_state_e;

  function automatic logic is_div_fn(input logic [ALU_FN_W-1:0] fn);
    return (fn == ALU_DIV) || (fn == ALU_DIVU) || (fn == ALU_REM) || (fn == ALU_REMU);
  endfunction

  function automatic logic is_signed_div_fn(input logic [ALU_FN_W-1:0] fn);
    return (fn == ALU_DIV) || (fn == ALU_REM);
  endfunction

endpackage

// File: rtl/reg_execute_div.sv
// Iterative restoring divider: one quotient bit per clock after start,
// magnitudes divided and signs applied on the final step.
module reg_execute_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_signed,
  input  logic            want_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            last,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic            active;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dsr_q;
  logic            neg_quo;
  logic            neg_rem;
  logic            want_rem_q;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;
  logic [XLEN-1:0] rem_n;
  logic [XLEN-1:0] quo_n;

  always_comb begin
    a_neg   = is_signed && dividend[XLEN-1];
    b_neg   = is_signed && divisor[XLEN-1];
    a_mag   = a_neg ? ('0 - dividend) : dividend;
    b_mag   = b_neg ? ('0 - divisor) : divisor;
    // quo_q doubles as the dividend shift register, so its MSB feeds the partial remainder
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dsr_q};
    fits    = !diff[XLEN];
    rem_n   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_n   = {quo_q[XLEN-2:0], fits};
    last    = active && (count == '0);
    if (want_rem_q) result = neg_rem ? ('0 - rem_n) : rem_n;
    else            result = neg_quo ? ('0 - quo_n) : quo_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active     <= 1'b0;
      count      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dsr_q      <= '0;
      neg_quo    <= 1'b0;
      neg_rem    <= 1'b0;
      want_rem_q <= 1'b0;
    end else if (start) begin
      active     <= 1'b1;
      count      <= CW'(XLEN - 1);
      rem_q      <= '0;
      quo_q      <= a_mag;
      dsr_q      <= b_mag;
      neg_quo    <= a_neg ^ b_neg;
      neg_rem    <= a_neg;
      want_rem_q <= want_rem;
    end else if (active) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      count <= count - CW'(1);
      if (count == '0) active <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_execute_alu.sv
// RV32 execute stage: single-cycle ALU with a registered valid/ready output.
// Define RV32M_EN to add multiply and the iterative divider (reg_execute_div).
module reg_execute_alu
  import reg_execute_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_FN_W-1:0] alu_fn,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  input  logic                wb_en,
  input  logic [4:0]          wb_addr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     alu_out,
  output logic                out_wb_en,
  output logic [4:0]          out_wb_addr,
  output logic                busy
);

  logic            slot_free;
  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] sum;
  logic [4:0]      shamt;

  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign sum       = rs1_data + rs2_data;
  assign shamt     = rs2_data[4:0];

`ifdef RV32M_EN
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  exe_state_e      state;
  logic [XLEN-1:0] hold_res;
  logic            div_wb_en;
  logic [4:0]      div_wb_addr;
  logic            div_by_zero;
  logic            div_ovf;
  logic            div_start;
  logic            div_last;
  logic [XLEN-1:0] div_result;
  logic            mul_a_signed;
  logic            mul_b_signed;
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] prod;

  assign in_ready = slot_free && (state == EXE_IDLE);
  assign busy     = (state != EXE_IDLE);

  assign div_by_zero = (rs2_data == '0);
  assign div_ovf     = is_signed_div_fn(alu_fn) && (rs1_data == INT_MIN) && (rs2_data == '1);
  // Special-case divisions finish through the single-cycle path, never the FSM
  assign div_start   = accept && is_div_fn(alu_fn) && !div_by_zero && !div_ovf;

  assign mul_a_signed = (alu_fn == ALU_MULH) || (alu_fn == ALU_MULHSU);
  assign mul_b_signed = (alu_fn == ALU_MULH);
  assign mul_a = {{XLEN{mul_a_signed & rs1_data[XLEN-1]}}, rs1_data};
  assign mul_b = {{XLEN{mul_b_signed & rs2_data[XLEN-1]}}, rs2_data};
  assign prod  = mul_a * mul_b;

  reg_execute_div #(
    .XLEN(XLEN)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .is_signed(is_signed_div_fn(alu_fn)),
    .want_rem ((alu_fn == ALU_REM) || (alu_fn == ALU_REMU)),
    .dividend (rs1_data),
    .divisor  (rs2_data),
    .last     (div_last),
    .result   (div_result)
  );
`else
  assign in_ready = slot_free;
  assign busy     = 1'b0;
`endif

  always_comb begin
    alu_res = '0;
    case (alu_fn)
      ALU_ADD:   alu_res = sum;
      ALU_SUB:   alu_res = rs1_data - rs2_data;
      ALU_AND:   alu_res = rs1_data & rs2_data;
      ALU_OR:    alu_res = rs1_data | rs2_data;
      ALU_XOR:   alu_res = rs1_data ^ rs2_data;
      ALU_SLL:   alu_res = rs1_data << shamt;
      ALU_SRL:   alu_res = rs1_data >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(rs1_data) >>> shamt);
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_data) < $signed(rs2_data)};
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, rs1_data < rs2_data};
      ALU_JALR:  alu_res = {sum[XLEN-1:1], 1'b0};
      ALU_COPY1: alu_res = rs1_data;
      ALU_COPY2: alu_res = rs2_data;
`ifdef RV32M_EN
      ALU_MUL:    alu_res = prod[XLEN-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  alu_res = prod[2*XLEN-1:XLEN];
      ALU_DIV,
      ALU_DIVU:   alu_res = div_by_zero ? '1 : (div_ovf ? INT_MIN : '0);
      ALU_REM,
      ALU_REMU:   alu_res = div_by_zero ? rs1_data : '0;
`endif
      default:   alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid   <= 1'b0;
      alu_out     <= '0;
      out_wb_en   <= 1'b0;
      out_wb_addr <= '0;
`ifdef RV32M_EN
      state       <= EXE_IDLE;
      hold_res    <= '0;
      div_wb_en   <= 1'b0;
      div_wb_addr <= '0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
`ifdef RV32M_EN
      case (state)
        EXE_IDLE: begin
          if (accept) begin
            if (div_start) begin
              div_wb_en   <= wb_en;
              div_wb_addr <= wb_addr;
              state       <= EXE_DIV;
            end else begin
              out_valid   <= 1'b1;
              alu_out     <= alu_res;
              out_wb_en   <= wb_en;
              out_wb_addr <= wb_addr;
            end
          end
        end
        EXE_DIV: begin
          if (div_last) begin
            if (slot_free) begin
              out_valid   <= 1'b1;
              alu_out     <= div_result;
              out_wb_en   <= div_wb_en;
              out_wb_addr <= div_wb_addr;
              state       <= EXE_IDLE;
            end else begin
              hold_res <= div_result;
              state    <= EXE_DONE;
            end
          end
        end
        EXE_DONE: begin
          if (slot_free) begin
            out_valid   <= 1'b1;
            alu_out     <= hold_res;
            out_wb_en   <= div_wb_en;
            out_wb_addr <= div_wb_addr;
            state       <= EXE_IDLE;
          end
        end
        default: state <= EXE_IDLE;
      endcase
`else
      if (accept) begin
        out_valid   <= 1'b1;
        alu_out     <= alu_res;
        out_wb_en   <= wb_en;
        out_wb_addr <= wb_addr;
      end
`endif
    end
  end

endmodule
